// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle control sequencer.
// Contents: the state encoding, the opcode values, the pc_src and alu_op
// codes, and an opcode classifier used by the FSM decode.
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  localparam logic [3:0] OP_LD  = 4'b0000;
  localparam logic [3:0] OP_ST  = 4'b0001;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_BNE = 4'b1100;
  localparam logic [3:0] OP_JMP = 4'b1101;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALU_OP_FUNCT = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_ADD   = 2'b10;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LD,
    CLS_ST,
    CLS_BEQ,
    CLS_BNE,
    CLS_JMP
  } op_class_e;

  // Any opcode without a dedicated class executes as an ALU instruction.
  function automatic op_class_e decode_op(input logic [3:0] op);
    op_class_e cls;
    case (op)
      OP_LD:   cls = CLS_LD;
      OP_ST:   cls = CLS_ST;
      OP_BEQ:  cls = CLS_BEQ;
      OP_BNE:  cls = CLS_BNE;
      OP_JMP:  cls = CLS_JMP;
      default: cls = CLS_ALU;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_hs_wait_timer.sv
// hs_wait_timer: counts consecutive cycles a memory request waits for ack.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   req         a request is outstanding this cycle
//   ack         acknowledge for that request (ignored while req = 0)
//   clr         clear the count (owner state is changing)
//   expired     request still unacknowledged after TIMEOUT_CYCLES wait cycles
// An ack in the limit cycle wins: expired requires ack = 0.
module hs_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ack,
  input  logic clr,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (req && ack)) begin
      cnt <= '0;
    end else if (req && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    expired = (TIMEOUT_CYCLES != 0) && req && !ack && (cnt == LIMIT);
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multi-cycle sequencer for the 16-bit RISC datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// PC, IR, ALU, register-file and memory-handshake controls.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   run                  start next instruction (sampled in FETCH)
//   opcode               IR[15:12]
//   zero_flag            ALU zero result (valid in EXEC)
//   imem_req/imem_ack    instruction fetch handshake
//   dmem_req/dmem_we/dmem_ack  data memory handshake (we = store)
//   ir_write, pc_write   IR load / PC update pulses
//   pc_src, alu_op       datapath mux and ALU operation selects
//   alu_src, reg_dst, mem_to_reg  datapath mux selects
//   reg_write            register-file write pulse
//   instr_done           pulse on the last cycle of each instruction
//   err                  sticky handshake-timeout error
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       zero_flag,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       alu_src,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       err
);

  state_e    state, state_next;
  op_class_e cls;
  logic      hs_req, hs_ack, hs_clr, hs_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Timer handshake inputs are derived from state rather than from the
  // decoded outputs so that expired does not feed back into its own source.
  always_comb begin
    hs_req = ((state == ST_FETCH) && run) || (state == ST_MEM);
    hs_ack = ((state == ST_FETCH) && run && imem_ack) ||
             ((state == ST_MEM) && dmem_ack);
    hs_clr = (state_next != state);
  end

  hs_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (hs_req),
    .ack     (hs_ack),
    .clr     (hs_clr),
    .expired (hs_expired)
  );

  // Outputs are gated by rst_n so that reset forces every output low
  // immediately, including imem_req which otherwise follows run in FETCH.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_SEQ;
    alu_op     = ALU_OP_FUNCT;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    err        = 1'b0;
    cls        = decode_op(opcode);

    if (rst_n) begin
      case (state)
        ST_FETCH: begin
          imem_req = run;
          if (run && imem_ack) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            pc_src     = PC_SRC_SEQ;
            state_next = ST_DECODE;
          end else if (hs_expired) begin
            state_next = ST_ERR;
          end
        end

        ST_DECODE: begin
          state_next = ST_EXEC;
        end

        ST_EXEC: begin
          case (cls)
            CLS_LD, CLS_ST: begin
              alu_op     = ALU_OP_ADD;
              alu_src    = 1'b1;
              state_next = ST_MEM;
            end
            CLS_BEQ, CLS_BNE: begin
              alu_op     = ALU_OP_SUB;
              pc_src     = PC_SRC_BRANCH;
              pc_write   = (cls == CLS_BEQ) ? zero_flag : !zero_flag;
              instr_done = 1'b1;
              state_next = ST_FETCH;
            end
            CLS_JMP: begin
              pc_src     = PC_SRC_JUMP;
              pc_write   = 1'b1;
              instr_done = 1'b1;
              state_next = ST_FETCH;
            end
            default: begin
              alu_op     = ALU_OP_FUNCT;
              alu_src    = 1'b0;
              state_next = ST_WB;
            end
          endcase
        end

        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls == CLS_ST);
          alu_op   = ALU_OP_ADD;
          alu_src  = 1'b1;
          if (dmem_ack) begin
            if (cls == CLS_ST) begin
              instr_done = 1'b1;
              state_next = ST_FETCH;
            end else begin
              state_next = ST_WB;
            end
          end else if (hs_expired) begin
            state_next = ST_ERR;
          end
        end

        ST_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          if (cls == CLS_LD) begin
            mem_to_reg = 1'b1;
          end else begin
            reg_dst = 1'b1;
          end
          state_next = ST_FETCH;
        end

        ST_ERR: begin
          err = 1'b1;
        end

        default: begin
          state_next = ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed testbench for multicycle_ctrl_fsm. Every cycle the full output
// vector is compared with a hand-written expected vector.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [3:0] opcode;
  logic       zero_flag;
  logic       imem_req, imem_ack;
  logic       dmem_req, dmem_we, dmem_ack;
  logic       ir_write, pc_write;
  logic [1:0] pc_src, alu_op;
  logic       alu_src, reg_dst, mem_to_reg, reg_write, instr_done, err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(
    .TIMEOUT_CYCLES (15),
    .CNT_W          (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .zero_flag  (zero_flag),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .alu_src    (alu_src),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .instr_done (instr_done),
    .err        (err)
  );

  // Bit order: imem_req dmem_req dmem_we ir_write pc_write pc_src[1:0]
  //            alu_op[1:0] alu_src reg_dst mem_to_reg reg_write instr_done err
  logic [14:0] outs;
  assign outs = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
                 alu_op, alu_src, reg_dst, mem_to_reg, reg_write, instr_done, err};

  localparam logic [14:0] V_ZERO    = 15'b0_0_0_0_0_00_00_0_0_0_0_0_0;
  localparam logic [14:0] F_WAIT    = 15'b1_0_0_0_0_00_00_0_0_0_0_0_0;
  localparam logic [14:0] F_ACK     = 15'b1_0_0_1_1_00_00_0_0_0_0_0_0;
  localparam logic [14:0] EX_MEM    = 15'b0_0_0_0_0_00_10_1_0_0_0_0_0;
  localparam logic [14:0] EX_BR_T   = 15'b0_0_0_0_1_01_01_0_0_0_0_1_0;
  localparam logic [14:0] EX_BR_N   = 15'b0_0_0_0_0_01_01_0_0_0_0_1_0;
  localparam logic [14:0] EX_JMP    = 15'b0_0_0_0_1_10_00_0_0_0_0_1_0;
  localparam logic [14:0] MEM_LD    = 15'b0_1_0_0_0_00_10_1_0_0_0_0_0;
  localparam logic [14:0] MEM_ST_W  = 15'b0_1_1_0_0_00_10_1_0_0_0_0_0;
  localparam logic [14:0] MEM_ST_A  = 15'b0_1_1_0_0_00_10_1_0_0_0_1_0;
  localparam logic [14:0] WB_ALU    = 15'b0_0_0_0_0_00_00_0_1_0_1_1_0;
  localparam logic [14:0] WB_LD     = 15'b0_0_0_0_0_00_00_0_0_1_1_1_0;
  localparam logic [14:0] V_ERR     = 15'b0_0_0_0_0_00_00_0_0_0_0_0_1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs 1ns later.
  task automatic cyc(input logic [3:0] op, input logic r, input logic ia,
                     input logic da, input logic zf, input logic [14:0] exp,
                     input string tag);
    @(negedge clk);
    opcode    = op;
    run       = r;
    imem_ack  = ia;
    dmem_ack  = da;
    zero_flag = zf;
    #1;
    check(tag, 32'(outs), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b1;
    #1;
    check("reset_outputs", 32'(outs), 32'(V_ZERO));
    @(negedge clk);
    run      = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; opcode = 4'b0010; zero_flag = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    check("reset_initial", 32'(outs), 32'(V_ZERO));
    repeat (2) @(negedge clk);
    run   = 1'b0;
    rst_n = 1'b1;

    // 1. ALU, zero-wait: 4 cycles
    cyc(4'b0010, 1, 1, 0, 0, F_ACK,  "alu_fetch");
    cyc(4'b0010, 1, 0, 0, 0, V_ZERO, "alu_decode");
    cyc(4'b0010, 1, 0, 0, 0, V_ZERO, "alu_exec");
    cyc(4'b0010, 1, 0, 0, 0, WB_ALU, "alu_wb");

    // 2. LD with dmem_ack after 3 wait cycles (back-to-back fetch)
    cyc(4'b0000, 1, 1, 0, 0, F_ACK,  "ld_fetch");
    cyc(4'b0000, 1, 0, 0, 0, V_ZERO, "ld_decode");
    cyc(4'b0000, 1, 0, 0, 0, EX_MEM, "ld_exec");
    cyc(4'b0000, 1, 0, 0, 0, MEM_LD, "ld_mem_w1");
    cyc(4'b0000, 1, 0, 0, 0, MEM_LD, "ld_mem_w2");
    cyc(4'b0000, 1, 0, 0, 0, MEM_LD, "ld_mem_w3");
    cyc(4'b0000, 1, 0, 1, 0, MEM_LD, "ld_mem_ack");
    cyc(4'b0000, 1, 0, 0, 0, WB_LD,  "ld_wb");

    // 3. BEQ taken, then BEQ not taken
    cyc(4'b1011, 1, 1, 0, 1, F_ACK,   "beq1_fetch");
    cyc(4'b1011, 1, 0, 0, 1, V_ZERO,  "beq1_decode");
    cyc(4'b1011, 1, 0, 0, 1, EX_BR_T, "beq1_exec");
    cyc(4'b1011, 1, 1, 0, 0, F_ACK,   "beq0_fetch");
    cyc(4'b1011, 1, 0, 0, 0, V_ZERO,  "beq0_decode");
    cyc(4'b1011, 1, 0, 0, 0, EX_BR_N, "beq0_exec");

    // 4. BNE taken / not taken, JMP
    cyc(4'b1100, 1, 1, 0, 0, F_ACK,   "bne0_fetch");
    cyc(4'b1100, 1, 0, 0, 0, V_ZERO,  "bne0_decode");
    cyc(4'b1100, 1, 0, 0, 0, EX_BR_T, "bne0_exec");
    cyc(4'b1100, 1, 1, 0, 1, F_ACK,   "bne1_fetch");
    cyc(4'b1100, 1, 0, 0, 1, V_ZERO,  "bne1_decode");
    cyc(4'b1100, 1, 0, 0, 1, EX_BR_N, "bne1_exec");
    cyc(4'b1101, 1, 1, 0, 0, F_ACK,   "jmp_fetch");
    cyc(4'b1101, 1, 0, 0, 0, V_ZERO,  "jmp_decode");
    cyc(4'b1101, 1, 0, 0, 0, EX_JMP,  "jmp_exec");

    // ST zero-wait: 4 cycles, done on the ack cycle
    cyc(4'b0001, 1, 1, 0, 0, F_ACK,    "st_fetch");
    cyc(4'b0001, 1, 0, 0, 0, V_ZERO,   "st_decode");
    cyc(4'b0001, 1, 0, 0, 0, EX_MEM,   "st_exec");
    cyc(4'b0001, 1, 0, 1, 0, MEM_ST_A, "st_mem_ack");

    // Unlisted opcode executes as ALU
    cyc(4'b0111, 1, 1, 0, 0, F_ACK,  "op7_fetch");
    cyc(4'b0111, 1, 0, 0, 0, V_ZERO, "op7_decode");
    cyc(4'b0111, 1, 0, 0, 0, V_ZERO, "op7_exec");
    cyc(4'b0111, 1, 0, 0, 0, WB_ALU, "op7_wb");

    // Ack ignored while run = 0
    cyc(4'b0010, 0, 1, 0, 0, V_ZERO, "idle_ack_ignored");
    cyc(4'b0010, 0, 1, 0, 0, V_ZERO, "idle_ack_ignored2");

    // 5a. ack arriving in the limit cycle (after 15 wait cycles) wins
    for (int unsigned i = 0; i < 15; i++) cyc(4'b0010, 1, 0, 0, 0, F_WAIT, "to_wait_a");
    cyc(4'b0010, 1, 1, 0, 0, F_ACK,  "to_ack_at_limit");
    cyc(4'b0010, 1, 0, 0, 0, V_ZERO, "to_ack_decode");
    cyc(4'b0010, 1, 0, 0, 0, V_ZERO, "to_ack_exec");
    cyc(4'b0010, 1, 0, 0, 0, WB_ALU, "to_ack_wb");

    // 5b. no ack: ERR after the limit cycle, sticky
    for (int unsigned i = 0; i < 16; i++) cyc(4'b0010, 1, 0, 0, 0, F_WAIT, "to_wait_b");
    cyc(4'b0010, 1, 1, 1, 0, V_ERR, "to_err");
    cyc(4'b0010, 1, 1, 1, 0, V_ERR, "to_err_sticky1");
    cyc(4'b0010, 0, 0, 0, 0, V_ERR, "to_err_sticky2");
    do_reset();

    // 6. reset during MEM of a store
    cyc(4'b0001, 1, 1, 0, 0, F_ACK,    "strst_fetch");
    cyc(4'b0001, 1, 0, 0, 0, V_ZERO,   "strst_decode");
    cyc(4'b0001, 1, 0, 0, 0, EX_MEM,   "strst_exec");
    cyc(4'b0001, 1, 0, 0, 0, MEM_ST_W, "strst_mem_wait");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("strst_async_drop", 32'(outs), 32'(V_ZERO));
    @(negedge clk);
    dmem_ack = 1'b1;
    #1;
    check("strst_held", 32'(outs), 32'(V_ZERO));
    rst_n = 1'b1;
    cyc(4'b0001, 0, 0, 0, 0, V_ZERO, "idle_after_rst1");
    cyc(4'b0001, 0, 1, 1, 0, V_ZERO, "idle_after_rst2");
    cyc(4'b0001, 0, 0, 0, 0, V_ZERO, "idle_after_rst3");
    cyc(4'b0010, 1, 1, 0, 0, F_ACK,  "resume_fetch");
    cyc(4'b0010, 1, 0, 0, 0, V_ZERO, "resume_decode");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
